// File: rtl/lc4_issue_queue.sv
// Four-slot in-order issue/retire queue: dispatch at tail, oldest-ready issue,
// out-of-order completion, in-order retirement from head.
module lc4_issue_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        dispatch,
    input  logic [15:0] dispatch_insn,
    input  logic        exec_ready,
    input  logic        complete,
    input  logic [1:0]  complete_tag,
    output logic [15:0] iq0_insn,
    output logic [15:0] iq1_insn,
    output logic [15:0] iq2_insn,
    output logic [15:0] iq3_insn,
    output logic [3:0]  iq_valid,
    output logic [3:0]  iq_issue,
    output logic [3:0]  iq_commit,
    output logic        rob_full,
    output logic        issue_valid,
    output logic [15:0] issue_insn,
    output logic [1:0]  issue_tag,
    output logic        retire_valid,
    output logic [1:0]  retire_tag,
    output logic [2:0]  count
);

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned INSN_W    = 16;
    localparam int unsigned TAG_W     = 2;
    localparam int unsigned CNT_W     = 3;

    logic [INSN_W-1:0]    insn_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid_q;
    logic [NUM_SLOTS-1:0] issue_q;
    logic [NUM_SLOTS-1:0] commit_q;
    logic [TAG_W-1:0]     head_q;
    logic [TAG_W-1:0]     tail_q;
    logic [CNT_W-1:0]     count_q;

    logic             cand_found;
    logic [TAG_W-1:0] cand_idx;
    logic             dispatch_ok;
    logic             issue_fire;
    logic             complete_ok;
    logic             retire_fire;

    // Oldest valid, not-yet-issued slot, scanning forward from head.
    always_comb begin
        logic [TAG_W-1:0] idx;
        cand_found = 1'b0;
        cand_idx   = '0;
        idx        = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            idx = head_q + TAG_W'(i);
            if (!cand_found && valid_q[idx] && !issue_q[idx]) begin
                cand_found = 1'b1;
                cand_idx   = idx;
            end
        end
    end

    // Full is judged on registered count only, so a same-cycle retire never frees a slot for dispatch.
    assign rob_full     = (count_q == CNT_W'(NUM_SLOTS));
    assign dispatch_ok  = !rst && dispatch && !rob_full;
    assign issue_fire   = !rst && exec_ready && cand_found;
    assign complete_ok  = !rst && complete && valid_q[complete_tag] && issue_q[complete_tag];
    assign retire_fire  = !rst && valid_q[head_q] && commit_q[head_q];

    assign issue_valid  = issue_fire;
    assign issue_insn   = cand_found ? insn_q[cand_idx] : '0;
    assign issue_tag    = cand_found ? cand_idx : '0;
    assign retire_valid = retire_fire;
    assign retire_tag   = head_q;

    assign iq0_insn  = insn_q[0];
    assign iq1_insn  = insn_q[1];
    assign iq2_insn  = insn_q[2];
    assign iq3_insn  = insn_q[3];
    assign iq_valid  = valid_q;
    assign iq_issue  = issue_q;
    assign iq_commit = commit_q;
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                insn_q[i] <= '0;
            end
            valid_q  <= '0;
            issue_q  <= '0;
            commit_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            if (issue_fire) begin
                issue_q[cand_idx] <= 1'b1;
            end
            if (complete_ok) begin
                commit_q[complete_tag] <= 1'b1;
            end
            if (dispatch_ok) begin
                insn_q[tail_q]   <= dispatch_insn;
                valid_q[tail_q]  <= 1'b1;
                issue_q[tail_q]  <= 1'b0;
                commit_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + TAG_W'(1);
            end
            // Retiring head slot never coincides with the other slot updates above.
            if (retire_fire) begin
                valid_q[head_q]  <= 1'b0;
                issue_q[head_q]  <= 1'b0;
                commit_q[head_q] <= 1'b0;
                head_q           <= head_q + TAG_W'(1);
            end
            count_q <= count_q + CNT_W'(dispatch_ok) - CNT_W'(retire_fire);
        end
    end

endmodule
